imem_loader: RTL and testbench

Writes a program image into the instruction memory through its write port; the instruction memory is the reader.
- Takes a byte stream over a valid/ready handshake and packs four bytes into one little-endian 32-bit instruction word.
- Writes words to consecutive word-aligned byte addresses, starting at 0.
- Holds the core (cpu_hold) for the whole load, so the core never fetches a partly written image.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for imem_loader.
// master = the loader itself, slave = the stream source / memory side.
interface imem_loader_if #(
    parameter int unsigned ADDR_BITS = 8
) ();
    logic                 start;
    logic [ADDR_BITS:0]   word_count;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 wr_en;
    logic [31:0]          wr_addr;
    logic [31:0]          wr_data;
    logic                 cpu_hold;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        input  start, word_count, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );

    modport slave (
        output start, word_count, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a byte stream into little-endian 32-bit words and writes them to
// consecutive instruction-memory addresses, holding the core for the whole load.
module imem_loader #(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, FIN} state_e;

    localparam logic [ADDR_BITS+1:0] DEPTH = {2'b01, {ADDR_BITS{1'b0}}};

    state_e             state_q;
    logic [1:0]         byte_cnt_q;
    logic [ADDR_BITS:0] word_idx_q;
    logic [ADDR_BITS:0] count_q;
    logic [23:0]        shift_q;
    logic               in_ready_q;
    logic               wr_en_q;
    logic [31:0]        wr_addr_q;
    logic [31:0]        wr_data_q;
    logic               cpu_hold_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [ADDR_BITS:0] word_idx_d;

    always_comb begin
        word_idx_d = word_idx_q + 1'b1;
    end

    // Outputs are registered alongside each state transition so they always
    // describe the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if ({1'b0, bus.word_count} > DEPTH) begin
                            error_q <= 1'b1;
                        end else if (bus.word_count == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            count_q    <= bus.word_count;
                            word_idx_q <= '0;
                            byte_cnt_q <= '0;
                            shift_q    <= '0;
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            cpu_hold_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        case (byte_cnt_q)
                            2'd0: shift_q[7:0]   <= bus.in_data;
                            2'd1: shift_q[15:8]  <= bus.in_data;
                            2'd2: shift_q[23:16] <= bus.in_data;
                            default: begin
                                // Byte 3 goes straight into the output word.
                                state_q    <= WRITE;
                                in_ready_q <= 1'b0;
                                wr_en_q    <= 1'b1;
                                wr_addr_q  <= 32'({word_idx_q, 2'b00});
                                wr_data_q  <= {bus.in_data, shift_q};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx_q <= word_idx_d;
                    if (word_idx_d == count_q) begin
                        state_q    <= FIN;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: request table, directed multi-cycle
// sequences, and randomized loads checked against a byte-packing reference.
module tb_imem_loader;
    localparam int unsigned AB = 8;

    logic clk = 1'b0;
    logic rst_n;

    imem_loader_if #(.ADDR_BITS(AB)) bus ();
    imem_loader #(.ADDR_BITS(AB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    typedef struct {
        logic [AB:0] wc;
        logic        exp_err;
        logic        exp_done;
    } req_t;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned hold_cnt = 0;
    int unsigned viol_cnt = 0;
    wr_t         wr_log[$];
    logic [7:0]  stream[$];
    int unsigned start_cyc, log_base, done_base, hold_base, viol_base;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle; the only writer of the log/counters.
    always @(negedge clk) begin
        if (bus.wr_en) wr_log.push_back('{bus.wr_addr, bus.wr_data, cyc});
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.cpu_hold) hold_cnt = hold_cnt + 1;
        if ((bus.done && bus.error) || (bus.busy != bus.cpu_hold) || (bus.wr_addr[1:0] != 2'b00) ||
            (bus.wr_en && (bus.in_ready || !bus.cpu_hold || !bus.busy)))
            viol_cnt = viol_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, ".wr_en"},    32'(bus.wr_en), 0);
        chk({tag, ".wr_addr"},  bus.wr_addr, 0);
        chk({tag, ".wr_data"},  bus.wr_data, 0);
        chk({tag, ".cpu_hold"}, 32'(bus.cpu_hold), 0);
        chk({tag, ".busy"},     32'(bus.busy), 0);
        chk({tag, ".done"},     32'(bus.done), 0);
        chk({tag, ".error"},    32'(bus.error), 0);
    endtask

    // Offers stream bytes until n have been accepted (in_valid & in_ready).
    task automatic feed(input int unsigned n, input int gap_at, input int unsigned gap_len,
                        input bit rnd, input bit poke);
        int unsigned idx = 0;
        int unsigned guard = 0;
        int unsigned gapped = 0;
        bit poked = 1'b0;
        bit acc;
        while (idx < n && guard < 8000) begin
            guard++;
            bus.start = 1'b0;
            if (poke && !poked && idx == 2) begin
                bus.start      = 1'b1;
                bus.word_count = 9'd5;
                poked          = 1'b1;
            end
            if (int'(idx) == gap_at && gapped < gap_len) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                gapped++;
                chk("ready_in_gap", 32'(bus.in_ready), 1);
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = stream[idx];
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) idx++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("feed_budget", idx, n);
    endtask

    // Full load of the current stream, compared against plain byte packing.
    task automatic do_load(input int unsigned cnt, input int gap_at, input int unsigned gap_len,
                           input bit rnd, input bit poke);
        int unsigned guard = 0;
        logic [31:0] exp_word;
        log_base  = wr_log.size();
        done_base = done_cnt;
        hold_base = hold_cnt;
        viol_base = viol_cnt;
        start_cyc = cyc;
        bus.word_count = cnt[AB:0];
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        feed(stream.size(), gap_at, gap_len, rnd, poke);
        while (done_cnt == done_base && guard < 40) begin
            step();
            guard++;
        end
        step();
        step();
        chk("write_count", wr_log.size() - log_base, cnt);
        for (int unsigned i = 0; i < cnt && log_base + i < wr_log.size(); i++) begin
            exp_word = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
            chk($sformatf("addr[%0d]", i), wr_log[log_base+i].addr, i * 4);
            chk($sformatf("data[%0d]", i), wr_log[log_base+i].data, exp_word);
        end
        chk("done_pulses", done_cnt - done_base, 1);
        chk("protocol", viol_cnt - viol_base, 0);
    endtask

    task automatic set_basic_stream();
        stream = '{8'h93, 8'h05, 8'h00, 8'h40, 8'h13, 8'h85, 8'h05, 8'h40};
    endtask

    initial begin
        req_t reqs[5];
        int unsigned cnt;
        int unsigned base;

        reqs[0] = '{9'd0,   1'b0, 1'b1};
        reqs[1] = '{9'd257, 1'b1, 1'b0};
        reqs[2] = '{9'd300, 1'b1, 1'b0};
        reqs[3] = '{9'd511, 1'b1, 1'b0};
        reqs[4] = '{9'd0,   1'b0, 1'b1};

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        step();
        step();
        chk_all_zero("reset");
        #2 rst_n = 1'b1;
        step();

        // Single-cycle requests from IDLE: rejection and empty loads.
        base = wr_log.size();
        foreach (reqs[i]) begin
            bus.word_count = reqs[i].wc;
            bus.start      = 1'b1;
            step();
            bus.start = 1'b0;
            chk($sformatf("req%0d.error", i), 32'(bus.error), 32'(reqs[i].exp_err));
            chk($sformatf("req%0d.done", i), 32'(bus.done), 32'(reqs[i].exp_done));
            chk($sformatf("req%0d.in_ready", i), 32'(bus.in_ready), 0);
            chk($sformatf("req%0d.busy", i), 32'(bus.busy), 0);
            step();
            chk($sformatf("req%0d.error_after", i), 32'(bus.error), 0);
            chk($sformatf("req%0d.done_after", i), 32'(bus.done), 0);
            chk($sformatf("req%0d.ready_after", i), 32'(bus.in_ready), 0);
        end
        chk("req_no_writes", wr_log.size() - base, 0);

        // Basic two-word load, stream never stalls.
        set_basic_stream();
        do_load(2, -1, 0, 1'b0, 1'b0);
        if (wr_log.size() >= log_base + 2) begin
            chk("basic.w0_cycle", wr_log[log_base].cyc - start_cyc, 5);
            chk("basic.w1_cycle", wr_log[log_base+1].cyc - start_cyc, 10);
        end
        chk("basic.done_cycle", done_cyc - start_cyc, 11);
        chk("basic.hold_cycles", hold_cnt - hold_base, 10);

        // Three idle stream cycles between bytes 1 and 2.
        set_basic_stream();
        do_load(2, 2, 3, 1'b0, 1'b0);
        if (wr_log.size() >= log_base + 2) begin
            chk("bp.w0_cycle", wr_log[log_base].cyc - start_cyc, 8);
            chk("bp.w1_cycle", wr_log[log_base+1].cyc - start_cyc, 13);
        end
        chk("bp.done_cycle", done_cyc - start_cyc, 14);
        chk("bp.hold_cycles", hold_cnt - hold_base, 13);

        // Second start with a different count while loading is ignored.
        set_basic_stream();
        do_load(2, -1, 0, 1'b0, 1'b1);

        // Reset in the middle of the second word.
        set_basic_stream();
        bus.word_count = 9'd2;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        feed(6, -1, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        #3 rst_n = 1'b1;
        step();
        stream = '{8'h13, 8'h00, 8'h00, 8'h00};
        do_load(1, -1, 0, 1'b0, 1'b0);
        if (wr_log.size() > log_base)
            chk("midreset.word", wr_log[log_base].data, 32'h0000_0013);

        // Full-depth load.
        stream.delete();
        for (int unsigned i = 0; i < 4 * (1 << AB); i++) stream.push_back(8'($urandom));
        do_load(1 << AB, -1, 0, 1'b0, 1'b0);
        if (wr_log.size() > 0)
            chk("full.last_addr", wr_log[wr_log.size()-1].addr, 32'h3FC);

        // Randomized loads with random stalls and stray start pulses.
        for (int unsigned it = 0; it < 12; it++) begin
            cnt = $urandom_range(1, 6);
            stream.delete();
            for (int unsigned i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
            do_load(cnt, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
